// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory with a fixed number of wait
// states per access. Accesses are IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP.
// Optional feature macro: DMEM_RANGE_CHECK_EN (out-of-range addresses raise
// err, writes are dropped, reads return 0). Without it addresses wrap.
module dmem_responder #(
    parameter int DATA_W      = 12,
    parameter int ADDR_W      = 12,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              dm_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_l;
    logic [DATA_W-1:0]   wdata_l;
    logic                we_l;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Access attributes as seen on the edge that enters RESP: with no wait
    // states that edge is the accepting edge, so the live inputs are used.
    logic [ADDR_W-1:0]     acc_addr;
    logic                  acc_we;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic                  acc_oor;

    assign acc_addr = (state == IDLE) ? addr  : addr_l;
    assign acc_we   = (state == IDLE) ? dm_en : we_l;
    assign acc_idx  = acc_addr[DEPTH_LOG2-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    assign acc_oor = (32'(acc_addr) >= (32'd1 << DEPTH_LOG2));
`else
    // High address bits are deliberately dropped: the address wraps.
    logic unused_hi;
    assign unused_hi = ^acc_addr[ADDR_W-1:DEPTH_LOG2];
    assign acc_oor   = 1'b0;
`endif

    assign busy = (state != IDLE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req) state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, wait counter, request latch and registered responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_l  <= '0;
            wdata_l <= '0;
            we_l    <= 1'b0;
            rdata   <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req) begin
                addr_l  <= addr;
                wdata_l <= wdata;
                we_l    <= dm_en;
            end
            if (state == IDLE && state_nxt == WAIT)
                cnt <= 4'(WAIT_CYCLES - 1);
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
            ready <= (state_nxt == RESP);
            err   <= (state_nxt == RESP) && acc_oor;
            if (state_nxt == RESP && !acc_we)
                rdata <= acc_oor ? '0 : mem[acc_idx];
        end
    end

    // Storage commits on the edge that ends RESP; err doubles as the
    // out-of-range flag of the access being completed. Not reset.
    always_ff @(posedge clk) begin
        if (state == RESP && we_l && !err)
            mem[addr_l[DEPTH_LOG2-1:0]] <= wdata_l;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 0, 15) sharing
// clock, reset and data inputs, each with its own req.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        we = 1'b0;
    logic [11:0] addr = '0;
    logic [11:0] wdata = '0;
    logic [11:0] rdata_o [3];
    logic [2:0]  ready_o, busy_o, err_o;

    int checks = 0;
    int errors = 0;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .dm_en(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[0]), .ready(ready_o[0]), .busy(busy_o[0]), .err(err_o[0]));
    dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .dm_en(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[1]), .ready(ready_o[1]), .busy(busy_o[1]), .err(err_o[1]));
    dmem_responder #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .dm_en(we), .addr(addr), .wdata(wdata),
        .rdata(rdata_o[2]), .ready(ready_o[2]), .busy(busy_o[2]), .err(err_o[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One access on instance sel; inputs are scrambled right after acceptance
    // so any use of live inputs mid-access shows up.
    task automatic acc(input int sel, input logic w, input logic [11:0] a, input logic [11:0] d,
                       input int wc, input logic [11:0] exp_rd, input logic exp_e, input string nm);
        int lat, bc;
        @(negedge clk);
        req[sel] = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req[sel] = 1'b0; we = ~w; addr = ~a; wdata = ~d;
        lat = 0;
        bc  = int'(busy_o[sel]);
        while (!ready_o[sel] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            bc += int'(busy_o[sel]);
        end
        chk({nm, "_lat"}, lat, wc);
        chk({nm, "_busycyc"}, bc, wc + 1);
        chk({nm, "_rdata"}, rdata_o[sel], exp_rd);
        chk({nm, "_err"}, err_o[sel], exp_e);
        @(posedge clk); #1;
        chk({nm, "_rdy_pulse"}, ready_o[sel], 1'b0);
        chk({nm, "_idle"}, busy_o[sel], 1'b0);
    endtask

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [11:0] d;
        logic [11:0] exp_rd;
    } vec_t;

    vec_t vt [9];
    int   extra;

    initial begin
        // Vectors for the WAIT_CYCLES=1 instance; exp_rd is rdata at ready
        // (writes leave it at the last read value).
        vt[0] = '{1'b1, 12'h005, 12'hABC, 12'h000};
        vt[1] = '{1'b0, 12'h005, 12'h000, 12'hABC};
        vt[2] = '{1'b1, 12'h009, 12'h555, 12'hABC};
        vt[3] = '{1'b0, 12'h009, 12'h000, 12'h555};
        vt[4] = '{1'b1, 12'h0FA, 12'h321, 12'h555};
        vt[5] = '{1'b0, 12'h005, 12'h000, 12'hABC};
        vt[6] = '{1'b0, 12'h0FA, 12'h000, 12'h321};
        vt[7] = '{1'b1, 12'h005, 12'hFFF, 12'h321};
        vt[8] = '{1'b0, 12'h005, 12'h000, 12'hFFF};

        // Reset state.
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_rdata", rdata_o[i], 12'h000);
            chk("rst_ready", ready_o[i], 1'b0);
            chk("rst_busy", busy_o[i], 1'b0);
            chk("rst_err", err_o[i], 1'b0);
        end
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            acc(0, vt[i].w, vt[i].a, vt[i].d, 1, vt[i].exp_rd, 1'b0, $sformatf("vec%0d", i));

        // Reset during WAIT aborts a write.
        acc(0, 1'b1, 12'h007, 12'h123, 1, 12'hFFF, 1'b0, "w7");
        @(negedge clk);
        req[0] = 1'b1; we = 1'b1; addr = 12'h007; wdata = 12'h456;
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("abort_busy", busy_o[0], 1'b1);
        rst_n = 1'b0; #1;
        chk("abort_rdata", rdata_o[0], 12'h000);
        chk("abort_ready", ready_o[0], 1'b0);
        chk("abort_idle", busy_o[0], 1'b0);
        @(posedge clk); #1;
        chk("abort_ready2", ready_o[0], 1'b0);
        @(negedge clk); rst_n = 1'b1;
        acc(0, 1'b0, 12'h007, 12'h000, 1, 12'h123, 1'b0, "r7");

        // Range check / wrap-around.
        acc(0, 1'b1, 12'h000, 12'h0AA, 1, 12'h123, 1'b0, "w0");
        acc(0, 1'b1, 12'h100, 12'h0BB, 1, 12'h123, RC, "w100");
        acc(0, 1'b0, 12'h000, 12'h000, 1, RC ? 12'h0AA : 12'h0BB, 1'b0, "r0");
        acc(0, 1'b0, 12'h100, 12'h000, 1, RC ? 12'h000 : 12'h0BB, RC, "r100");

        // Back-to-back on WAIT_CYCLES=0 with req held high, addr 3.
        @(negedge clk);
        req[1] = 1'b1; addr = 12'h003; we = 1'b1; wdata = 12'h200;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_rdy%0d", j), ready_o[1], 1'b1);
            if (j % 2 == 1) chk($sformatf("b2b_rd%0d", j), rdata_o[1], 12'h200 + j - 1);
            we = (j % 2 == 1);
            wdata = 12'(12'h200 + j + 1);
            @(posedge clk); #1;
            chk($sformatf("b2b_gap%0d", j), ready_o[1], 1'b0);
            chk($sformatf("b2b_idle%0d", j), busy_o[1], 1'b0);
        end
        req[1] = 1'b0;

        // WAIT_CYCLES=15: 16 busy cycles, single ready.
        acc(2, 1'b1, 12'h005, 12'h777, 15, 12'h000, 1'b0, "w15w");
        acc(2, 1'b0, 12'h005, 12'h000, 15, 12'h777, 1'b0, "w15r");
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            extra += int'(ready_o[2]);
        end
        chk("w15_no_second", extra, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
